// File: rtl/ftf_seq_decoder_12.sv
// Sequential FTF/FNS codeword decoder: captures a LEN-wire TSV word, accumulates Fibonacci weights one wire per cycle.
// Optional legality checker and saturating error counter enabled by defining FTF_CHECK_EN.
module ftf_seq_decoder_12 #(
  parameter int LEN    = 12,
  parameter int DATA_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [LEN-1:0]    tsv_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              code_err,
  output logic [CNT_W-1:0]  err_count
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [LEN-1:0]    shift_q, shift_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] step_sum;
  logic              capture;
  logic              last_step;

  assign step_sum  = acc_q + (shift_q[0] ? a_q : '0);
  assign capture   = (state_q == S_IDLE) && in_valid;
  assign last_step = (state_q == S_ACCUM) && (cnt_q == CW'(LEN - 1));

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          shift_d = tsv_in;
          acc_d   = '0;
          a_d     = DATA_W'(1);
          b_d     = DATA_W'(1);
          cnt_d   = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        // LSB-first: the running pair (a,b) walks the Fibonacci weights alongside the shift.
        acc_d   = step_sum;
        a_d     = b_q;
        b_d     = a_q + b_q;
        shift_d = shift_q >> 1;
        if (last_step) begin
          data_d  = step_sum;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_data  = data_q;

`ifdef FTF_CHECK_EN
  // Even i forbids (0,1) on wires (i,i+1); odd i forbids (1,0).
  function automatic logic ftf_illegal(input logic [LEN-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < LEN - 1; i++) begin
      if ((i % 2) == 0) bad = bad | (~w[i] & w[i+1]);
      else              bad = bad | (w[i] & ~w[i+1]);
    end
    return bad;
  endfunction

  logic             flag_q, flag_d;
  logic             code_err_q, code_err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    flag_d     = flag_q;
    code_err_d = code_err_q;
    err_cnt_d  = err_cnt_q;
    if (capture)   flag_d     = ftf_illegal(tsv_in);
    if (last_step) code_err_d = flag_q;
    if (out_valid && out_ready && code_err_q && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      flag_q     <= 1'b0;
      code_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      flag_q     <= flag_d;
      code_err_q <= code_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign code_err  = code_err_q;
  assign err_count = err_cnt_q;
`else
  assign code_err  = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_ftf_seq_decoder_12.sv
// Directed and table-driven bench for ftf_seq_decoder_12; expectations follow FTF_CHECK_EN when it is defined.
module tb_ftf_seq_decoder_12;

  localparam int LEN    = 12;
  localparam int DATA_W = 9;
  localparam int CNT_W  = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic [LEN-1:0]    tsv_in;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              code_err;
  logic [CNT_W-1:0]  err_count;

  int passed = 0;
  int total  = 0;
  int exp_cnt = 0;

  ftf_seq_decoder_12 #(.LEN(LEN), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .tsv_in(tsv_in), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .code_err(code_err), .err_count(err_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [LEN-1:0]    tsv;
    logic [DATA_W-1:0] data;
    logic              err;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic eff_err(input logic e);
`ifdef FTF_CHECK_EN
    return e;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic is_legal(input logic [LEN-1:0] w);
    for (int i = 0; i < LEN - 1; i++) begin
      if ((i % 2) == 0 && !w[i] && w[i+1]) return 1'b0;
      if ((i % 2) == 1 && w[i] && !w[i+1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int fib_value(input logic [LEN-1:0] w);
    int wt [LEN] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144};
    int v = 0;
    for (int i = 0; i < LEN; i++) if (w[i]) v += wt[i];
    return v;
  endfunction

  // Waits for in_ready, then presents one word for a single capture edge.
  task automatic send_capture(input logic [LEN-1:0] w);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clock); #1; n++;
    end
    check("in_ready before send", 32'(in_ready), 32'd1);
    tsv_in = w; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; tsv_in = '0;
  endtask

  task automatic wait_out(input string name);
    int lat = 0;
    do begin
      @(posedge clock); #1; lat++;
    end while (!out_valid && lat < LEN + 8);
    check({name, " latency"}, 32'(lat), 32'(LEN));
  endtask

  // Full transaction with out_ready held high.
  task automatic do_word(input logic [LEN-1:0] w, input logic [DATA_W-1:0] d, input logic e, input string name);
    out_ready = 1'b1;
    send_capture(w);
    wait_out(name);
    check({name, " out_data"}, 32'(out_data), 32'(d));
    check({name, " code_err"}, 32'(code_err), 32'(eff_err(e)));
    if (eff_err(e) && exp_cnt < 65535) exp_cnt++;
    @(posedge clock); #1;
    check({name, " out_valid after hs"}, 32'(out_valid), 32'd0);
    check({name, " in_ready after hs"}, 32'(in_ready), 32'd1);
    check({name, " err_count"}, 32'(err_count), 32'(exp_cnt));
  endtask

  logic [LEN-1:0] enc [377];
  bit             have [377];

  initial begin
    vecs[0]  = '{12'h000,          9'd0,   1'b0};
    vecs[1]  = '{12'hFFF,          9'd376, 1'b0};
    vecs[2]  = '{12'b000000000001, 9'd1,   1'b0};
    vecs[3]  = '{12'b000000000010, 9'd1,   1'b1};
    vecs[4]  = '{12'b100000000000, 9'd144, 1'b1};
    vecs[5]  = '{12'b010000000000, 9'd89,  1'b0};
    vecs[6]  = '{12'b110000000000, 9'd233, 1'b0};
    vecs[7]  = '{12'b000000000111, 9'd4,   1'b0};
    vecs[8]  = '{12'b000000000100, 9'd2,   1'b0};
    vecs[9]  = '{12'b000000001000, 9'd3,   1'b1};
    vecs[10] = '{12'b101010101010, 9'd232, 1'b1};
    vecs[11] = '{12'b010101010101, 9'd144, 1'b0};

    // Reference encoder table: each legal codeword indexed by its value.
    for (int w = 0; w < 4096; w++) begin
      logic [LEN-1:0] cw;
      int v;
      cw = LEN'(w);
      if (is_legal(cw)) begin
        v = fib_value(cw);
        if (v <= 376) begin enc[v] = cw; have[v] = 1'b1; end
      end
    end

    reset = 1'b1; tsv_in = '0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset code_err", 32'(code_err), 32'd0);
    check("reset err_count", 32'(err_count), 32'd0);

    for (int k = 0; k < 12; k++)
      do_word(vecs[k].tsv, vecs[k].data, vecs[k].err, $sformatf("vec%0d", k));

    // Backpressure: result must hold and a new word must not be captured.
    out_ready = 1'b0;
    send_capture(12'b000011111111);
    wait_out("bp");
    for (int k = 0; k < 5; k++) begin
      tsv_in = 12'hFFF; in_valid = 1'b1;
      @(posedge clock); #1;
      check("bp out_valid held", 32'(out_valid), 32'd1);
      check("bp out_data held", 32'(out_data), 32'd54);
      check("bp in_ready low", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; tsv_in = '0; out_ready = 1'b1;
    @(posedge clock); #1;
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);
    do_word(12'b000000000001, 9'd1, 1'b0, "after bp");

    // Reset during the sixth ACCUM cycle discards the word.
    send_capture(12'b000011111111);
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    exp_cnt = 0;
    check("midrst in_ready", 32'(in_ready), 32'd1);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst err_count", 32'(err_count), 32'd0);
    repeat (LEN + 2) @(posedge clock);
    #1 check("midrst no stale output", 32'(out_valid), 32'd0);
    do_word(12'hFFF, 9'd376, 1'b0, "after midrst");

    // Legal-codeword sweep: every value once, then random values.
    for (int v = 0; v <= 376; v++)
      if (have[v]) do_word(enc[v], DATA_W'(v), 1'b0, $sformatf("sweep%0d", v));
    for (int k = 0; k < 1000; k++) begin
      int v;
      v = int'($urandom_range(0, 376));
      if (have[v]) do_word(enc[v], DATA_W'(v), 1'b0, $sformatf("rand%0d", v));
    end
    check("final err_count", 32'(err_count), 32'(exp_cnt));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
